// File: rtl/issue_queue_decoder_pkg.sv
// Shared opcode constants, default sizes and immediate generation for the
// issue-queue decoder slice.
package issue_queue_decoder_pkg;

  localparam int XLEN_DEF           = 32;
  localparam int IQ_DEPTH_DEF       = 4;
  localparam int ROB_SIZE_WIDTH_DEF = 4;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  // 32-bit sign-extended immediate selected by instruction format
  function automatic logic [31:0] imm_gen(input logic [31:0] ins);
    logic [31:0] imm;
    case (ins[6:0])
      OPC_LUI, OPC_AUIPC:            imm = {ins[31:12], 12'b0};
      OPC_JAL:                       imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      OPC_JALR, OPC_LOAD, OPC_OPIMM: imm = {{20{ins[31]}}, ins[31:20]};
      OPC_BRANCH:                    imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      OPC_STORE:                     imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      default:                       imm = 32'b0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/issue_queue_decoder_iq_fifo.sv
// Synchronous FIFO with flush, global enable and full/empty status.
// Read data is the combinational head entry.
module iq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = en && !flush && push && !full;
  assign do_pop  = en && !flush && pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (en && flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/issue_queue_decoder.sv
// Instruction queue with static branch prediction at enqueue and
// single-issue decode of the queue head toward RoB plus RS or LSB.
module issue_queue_decoder
  import issue_queue_decoder_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int IQ_DEPTH       = IQ_DEPTH_DEF,
  parameter int ROB_SIZE_WIDTH = ROB_SIZE_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      fetch_valid,
  input  logic [31:0]               fetch_instr,
  input  logic [XLEN-1:0]           fetch_pc,
  output logic                      fetch_ready,
  output logic                      redirect_valid,
  output logic [XLEN-1:0]           redirect_pc,
  input  logic                      rob_full,
  input  logic                      rs_full,
  input  logic                      lsb_full,
  input  logic [ROB_SIZE_WIDTH-1:0] rob_tail_id,
  output logic [4:0]                reg_id1,
  output logic [4:0]                reg_id2,
  input  logic [XLEN-1:0]           reg_val1,
  input  logic [XLEN-1:0]           reg_val2,
  input  logic                      reg_dep1,
  input  logic                      reg_dep2,
  input  logic [ROB_SIZE_WIDTH-1:0] reg_q1,
  input  logic [ROB_SIZE_WIDTH-1:0] reg_q2,
  output logic                      issue_valid,
  output logic                      to_rs,
  output logic                      to_lsb,
  output logic [31:0]               iss_instr,
  output logic [XLEN-1:0]           iss_pc,
  output logic [6:0]                iss_opcode,
  output logic [2:0]                iss_funct3,
  output logic [XLEN-1:0]           iss_imm,
  output logic [4:0]                iss_rd,
  output logic                      iss_has_rd,
  output logic [XLEN-1:0]           iss_v1,
  output logic [XLEN-1:0]           iss_v2,
  output logic                      iss_dep1,
  output logic                      iss_dep2,
  output logic [ROB_SIZE_WIDTH-1:0] iss_q1,
  output logic [ROB_SIZE_WIDTH-1:0] iss_q2,
  output logic [ROB_SIZE_WIDTH-1:0] iss_rob_id,
  output logic                      iss_pred_taken,
  output logic [XLEN-1:0]           iss_pred_pc
);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            pred_taken;
    logic [XLEN-1:0] pred_pc;
  } entry_t;

  typedef struct packed {
    logic                      to_rs;
    logic                      to_lsb;
    logic [31:0]               instr;
    logic [XLEN-1:0]           pc;
    logic [XLEN-1:0]           imm;
    logic                      has_rd;
    logic [XLEN-1:0]           v1;
    logic [XLEN-1:0]           v2;
    logic                      dep1;
    logic                      dep2;
    logic [ROB_SIZE_WIDTH-1:0] q1;
    logic [ROB_SIZE_WIDTH-1:0] q2;
    logic [ROB_SIZE_WIDTH-1:0] rob_id;
    logic                      pred_taken;
    logic [XLEN-1:0]           pred_pc;
  } iss_t;

  // Fetch side: immediate, prediction and enqueue qualification
  logic [6:0]             f_op;
  logic signed [XLEN-1:0] f_imm;
  logic [XLEN-1:0]        f_target;
  logic                   f_taken;
  logic                   enq;
  logic                   fifo_full, fifo_empty;
  entry_t                 f_entry, head;

  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            issue_valid_q, issue_valid_d;
  iss_t            iss_q, iss_d;

  assign f_op        = fetch_instr[6:0];
  assign f_imm       = XLEN'(signed'(imm_gen(fetch_instr)));
  assign f_target    = fetch_pc + f_imm;
  assign f_taken     = (f_op == OPC_JAL) || ((f_op == OPC_BRANCH) && f_imm[XLEN-1]);
  assign fetch_ready = !fifo_full;
  assign enq         = fetch_valid && fetch_ready && !redirect_valid_q;

  assign f_entry.instr      = fetch_instr;
  assign f_entry.pc         = fetch_pc;
  assign f_entry.imm        = f_imm;
  assign f_entry.pred_taken = f_taken;
  assign f_entry.pred_pc    = f_taken ? f_target : fetch_pc + XLEN'(4);

  // Head decode: destination, operand usage and issue readiness
  logic [6:0] h_op;
  logic [4:0] h_rs1, h_rs2, h_rd;
  logic       h_lsb, h_rs, h_use1, h_use2, h_has_rd, h_dest_ok, issue_go;

  assign h_op     = head.instr[6:0];
  assign h_rs1    = head.instr[19:15];
  assign h_rs2    = head.instr[24:20];
  assign h_rd     = head.instr[11:7];
  assign h_lsb    = (h_op == OPC_LOAD) || (h_op == OPC_STORE);
  assign h_rs     = (h_op == OPC_LUI) || (h_op == OPC_AUIPC) || (h_op == OPC_JAL) ||
                    (h_op == OPC_JALR) || (h_op == OPC_BRANCH) || (h_op == OPC_OP) ||
                    (h_op == OPC_OPIMM);
  assign h_use1   = !((h_op == OPC_LUI) || (h_op == OPC_AUIPC) || (h_op == OPC_JAL));
  assign h_use2   = (h_op == OPC_OP) || (h_op == OPC_STORE) || (h_op == OPC_BRANCH);
  assign h_has_rd = (h_rd != 5'd0) && (h_op != OPC_BRANCH) && (h_op != OPC_STORE);
  assign h_dest_ok = h_lsb ? !lsb_full : (h_rs ? !rs_full : 1'b1);
  assign issue_go = rdy && !flush && !fifo_empty && !rob_full && h_dest_ok;

  assign reg_id1 = h_rs1;
  assign reg_id2 = h_rs2;

  iq_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (IQ_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .en    (rdy),
    .flush (flush),
    .push  (enq),
    .pop   (issue_go),
    .din   (f_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Operand resolution: unused/x0 zeroed, last-issue bypass beats the regfile
  logic [XLEN-1:0]           op_v1, op_v2;
  logic                      op_d1, op_d2;
  logic [ROB_SIZE_WIDTH-1:0] op_q1, op_q2;
  logic                      byp1, byp2;

  assign byp1 = issue_valid_q && iss_q.has_rd && (iss_q.instr[11:7] == h_rs1);
  assign byp2 = issue_valid_q && iss_q.has_rd && (iss_q.instr[11:7] == h_rs2);

  // Per-operand value/dependency selection
  always_comb begin
    op_v1 = '0; op_d1 = 1'b0; op_q1 = '0;
    op_v2 = '0; op_d2 = 1'b0; op_q2 = '0;
    if (h_use1 && (h_rs1 != 5'd0)) begin
      if (byp1) begin
        op_d1 = 1'b1; op_q1 = iss_q.rob_id;
      end else begin
        op_v1 = reg_val1; op_d1 = reg_dep1; op_q1 = reg_q1;
      end
    end
    if (h_use2 && (h_rs2 != 5'd0)) begin
      if (byp2) begin
        op_d2 = 1'b1; op_q2 = iss_q.rob_id;
      end else begin
        op_v2 = reg_val2; op_d2 = reg_dep2; op_q2 = reg_q2;
      end
    end
  end

  // Next-state for redirect and issue registers; rdy low holds everything
  always_comb begin
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    issue_valid_d    = issue_valid_q;
    iss_d            = iss_q;
    if (rdy) begin
      if (flush) begin
        redirect_valid_d = 1'b0;
        issue_valid_d    = 1'b0;
      end else begin
        redirect_valid_d = enq && f_taken;
        if (enq && f_taken) redirect_pc_d = f_target;
        issue_valid_d = issue_go;
        if (issue_go) begin
          iss_d.to_rs      = h_rs;
          iss_d.to_lsb     = h_lsb;
          iss_d.instr      = head.instr;
          iss_d.pc         = head.pc;
          iss_d.imm        = head.imm;
          iss_d.has_rd     = h_has_rd;
          iss_d.v1         = op_v1;
          iss_d.v2         = op_v2;
          iss_d.dep1       = op_d1;
          iss_d.dep2       = op_d2;
          iss_d.q1         = op_q1;
          iss_d.q2         = op_q2;
          iss_d.rob_id     = rob_tail_id;
          iss_d.pred_taken = head.pred_taken;
          iss_d.pred_pc    = head.pred_pc;
        end
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      issue_valid_q    <= 1'b0;
      iss_q            <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      issue_valid_q    <= issue_valid_d;
      iss_q            <= iss_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign issue_valid    = issue_valid_q;
  assign to_rs          = iss_q.to_rs;
  assign to_lsb         = iss_q.to_lsb;
  assign iss_instr      = iss_q.instr;
  assign iss_pc         = iss_q.pc;
  assign iss_opcode     = iss_q.instr[6:0];
  assign iss_funct3     = iss_q.instr[14:12];
  assign iss_imm        = iss_q.imm;
  assign iss_rd         = iss_q.instr[11:7];
  assign iss_has_rd     = iss_q.has_rd;
  assign iss_v1         = iss_q.v1;
  assign iss_v2         = iss_q.v2;
  assign iss_dep1       = iss_q.dep1;
  assign iss_dep2       = iss_q.dep2;
  assign iss_q1         = iss_q.q1;
  assign iss_q2         = iss_q.q2;
  assign iss_rob_id     = iss_q.rob_id;
  assign iss_pred_taken = iss_q.pred_taken;
  assign iss_pred_pc    = iss_q.pred_pc;

endmodule

// File: tb/tb_issue_queue_decoder.sv
// Directed bench for issue_queue_decoder: reset, single issue, rename
// bypass, branch prediction, LSB backpressure, flush and rdy freeze.
module tb_issue_queue_decoder;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, fetch_valid;
  logic [31:0] fetch_instr, fetch_pc;
  logic        fetch_ready, redirect_valid;
  logic [31:0] redirect_pc;
  logic        rob_full, rs_full, lsb_full;
  logic [3:0]  rob_tail_id;
  logic [4:0]  reg_id1, reg_id2;
  logic [31:0] reg_val1, reg_val2;
  logic        reg_dep1, reg_dep2;
  logic [3:0]  reg_q1, reg_q2;
  logic        issue_valid, to_rs, to_lsb;
  logic [31:0] iss_instr, iss_pc;
  logic [6:0]  iss_opcode;
  logic [2:0]  iss_funct3;
  logic [31:0] iss_imm;
  logic [4:0]  iss_rd;
  logic        iss_has_rd;
  logic [31:0] iss_v1, iss_v2;
  logic        iss_dep1, iss_dep2;
  logic [3:0]  iss_q1, iss_q2, iss_rob_id;
  logic        iss_pred_taken;
  logic [31:0] iss_pred_pc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  issue_queue_decoder #(.XLEN(32), .IQ_DEPTH(4), .ROB_SIZE_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full), .rob_tail_id(rob_tail_id),
    .reg_id1(reg_id1), .reg_id2(reg_id2), .reg_val1(reg_val1), .reg_val2(reg_val2),
    .reg_dep1(reg_dep1), .reg_dep2(reg_dep2), .reg_q1(reg_q1), .reg_q2(reg_q2),
    .issue_valid(issue_valid), .to_rs(to_rs), .to_lsb(to_lsb),
    .iss_instr(iss_instr), .iss_pc(iss_pc), .iss_opcode(iss_opcode), .iss_funct3(iss_funct3),
    .iss_imm(iss_imm), .iss_rd(iss_rd), .iss_has_rd(iss_has_rd),
    .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_dep1(iss_dep1), .iss_dep2(iss_dep2),
    .iss_q1(iss_q1), .iss_q2(iss_q2), .iss_rob_id(iss_rob_id),
    .iss_pred_taken(iss_pred_taken), .iss_pred_pc(iss_pred_pc)
  );

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; fetch_valid = 1'b0;
    fetch_instr = '0; fetch_pc = '0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; rob_tail_id = '0;
    reg_val1 = 32'h0000_1234; reg_val2 = 32'h0000_5678;
    reg_dep1 = 1'b0; reg_dep2 = 1'b0; reg_q1 = '0; reg_q2 = '0;
    @(negedge clk); @(negedge clk);
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL rst_issue_valid got=%0h exp=0", issue_valid); end
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL rst_redirect_valid got=%0h exp=0", redirect_valid); end
    checks++; if (iss_pc !== 32'h0) begin failures++; $display("FAIL rst_iss_pc got=%0h exp=0", iss_pc); end
    checks++; if (iss_instr !== 32'h0) begin failures++; $display("FAIL rst_iss_instr got=%0h exp=0", iss_instr); end
    checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL rst_fetch_ready got=%0h exp=1", fetch_ready); end
    rst = 1'b0;
  endtask

  // addi x1,x0,5 at pc 0
  task automatic test_single_issue();
    @(negedge clk);
    fetch_valid = 1'b1; fetch_instr = 32'h0050_0093; fetch_pc = 32'h0; rob_tail_id = 4'd3;
    @(negedge clk);
    fetch_valid = 1'b0;
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL addi_no_early_issue got=%0h exp=0", issue_valid); end
    @(negedge clk);
    checks++; if (issue_valid !== 1'b1) begin failures++; $display("FAIL addi_issue got=%0h exp=1", issue_valid); end
    checks++; if (to_rs !== 1'b1 || to_lsb !== 1'b0) begin failures++; $display("FAIL addi_dest got=%0b%0b exp=10", to_rs, to_lsb); end
    checks++; if (iss_imm !== 32'd5) begin failures++; $display("FAIL addi_imm got=%0h exp=5", iss_imm); end
    checks++; if (iss_rd !== 5'd1 || iss_has_rd !== 1'b1) begin failures++; $display("FAIL addi_rd got=%0d/%0b exp=1/1", iss_rd, iss_has_rd); end
    checks++; if (iss_dep1 !== 1'b0 || iss_v1 !== 32'h0) begin failures++; $display("FAIL addi_op1 got=%0b/%0h exp=0/0", iss_dep1, iss_v1); end
    checks++; if (iss_rob_id !== 4'd3) begin failures++; $display("FAIL addi_rob_id got=%0d exp=3", iss_rob_id); end
    checks++; if (iss_pred_taken !== 1'b0 || iss_pred_pc !== 32'h4) begin failures++; $display("FAIL addi_pred got=%0b/%0h exp=0/4", iss_pred_taken, iss_pred_pc); end
    checks++; if (iss_opcode !== 7'h13 || iss_funct3 !== 3'd0) begin failures++; $display("FAIL addi_fields got=%0h/%0h exp=13/0", iss_opcode, iss_funct3); end
    @(negedge clk);
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL addi_pulse got=%0h exp=0", issue_valid); end
  endtask

  // addi x1,x0,5 then add x2,x1,x1: second must take x1 from the first's tag
  task automatic test_back_to_back();
    @(negedge clk);
    fetch_valid = 1'b1; fetch_instr = 32'h0050_0093; fetch_pc = 32'h10; rob_tail_id = 4'd5;
    @(negedge clk);
    fetch_instr = 32'h0010_8133; fetch_pc = 32'h14;
    @(negedge clk);
    fetch_valid = 1'b0;
    checks++; if (issue_valid !== 1'b1 || iss_rd !== 5'd1 || iss_rob_id !== 4'd5) begin failures++; $display("FAIL b2b_first got=%0b/%0d/%0d exp=1/1/5", issue_valid, iss_rd, iss_rob_id); end
    rob_tail_id = 4'd6;
    @(negedge clk);
    checks++; if (issue_valid !== 1'b1 || iss_rd !== 5'd2 || iss_pc !== 32'h14) begin failures++; $display("FAIL b2b_second got=%0b/%0d/%0h exp=1/2/14", issue_valid, iss_rd, iss_pc); end
    checks++; if (iss_dep1 !== 1'b1 || iss_q1 !== 4'd5) begin failures++; $display("FAIL b2b_bypass1 got=%0b/%0d exp=1/5", iss_dep1, iss_q1); end
    checks++; if (iss_dep2 !== 1'b1 || iss_q2 !== 4'd5) begin failures++; $display("FAIL b2b_bypass2 got=%0b/%0d exp=1/5", iss_dep2, iss_q2); end
    checks++; if (iss_rob_id !== 4'd6) begin failures++; $display("FAIL b2b_rob_id got=%0d exp=6", iss_rob_id); end
  endtask

  // beq x0,x0,-8 at pc 0x40 followed by a wrong-path beat
  task automatic test_branch_predict();
    @(negedge clk);
    fetch_valid = 1'b1; fetch_instr = 32'hFE00_0CE3; fetch_pc = 32'h40;
    @(negedge clk);
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h38) begin failures++; $display("FAIL br_redirect got=%0b/%0h exp=1/38", redirect_valid, redirect_pc); end
    fetch_instr = 32'h0010_0293; fetch_pc = 32'h44;
    @(negedge clk);
    fetch_valid = 1'b0;
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL br_redirect_pulse got=%0b exp=0", redirect_valid); end
    checks++; if (issue_valid !== 1'b1 || iss_pc !== 32'h40 || to_rs !== 1'b1) begin failures++; $display("FAIL br_issue got=%0b/%0h/%0b exp=1/40/1", issue_valid, iss_pc, to_rs); end
    checks++; if (iss_pred_taken !== 1'b1 || iss_pred_pc !== 32'h38) begin failures++; $display("FAIL br_pred got=%0b/%0h exp=1/38", iss_pred_taken, iss_pred_pc); end
    checks++; if (iss_imm !== 32'hFFFF_FFF8 || iss_has_rd !== 1'b0) begin failures++; $display("FAIL br_imm got=%0h/%0b exp=fffffff8/0", iss_imm, iss_has_rd); end
    @(negedge clk);
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL br_shadow_dropped got=%0b exp=0", issue_valid); end
  endtask

  // lw x3,0(x0) blocked by lsb_full while three addi fill the queue; leaves three entries
  task automatic test_lsb_stall();
    lsb_full = 1'b1;
    @(negedge clk);
    fetch_valid = 1'b1; fetch_instr = 32'h0000_2183; fetch_pc = 32'h80;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      fetch_instr = 32'h0070_0213; fetch_pc = 32'h80 + 32'(4 * i);
    end
    @(negedge clk);
    fetch_valid = 1'b0;
    checks++; if (fetch_ready !== 1'b0) begin failures++; $display("FAIL lsb_full_ready got=%0b exp=0", fetch_ready); end
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL lsb_stall_issue got=%0b exp=0", issue_valid); end
    @(negedge clk);
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL lsb_stall_hold got=%0b exp=0", issue_valid); end
    lsb_full = 1'b0;
    #1;
    checks++; if (fetch_ready !== 1'b0) begin failures++; $display("FAIL lsb_ready_prepop got=%0b exp=0", fetch_ready); end
    @(negedge clk);
    checks++; if (issue_valid !== 1'b1 || to_lsb !== 1'b1 || to_rs !== 1'b0) begin failures++; $display("FAIL lsb_issue got=%0b/%0b/%0b exp=1/1/0", issue_valid, to_lsb, to_rs); end
    checks++; if (iss_rd !== 5'd3 || iss_pc !== 32'h80 || iss_funct3 !== 3'd2) begin failures++; $display("FAIL lsb_fields got=%0d/%0h/%0d exp=3/80/2", iss_rd, iss_pc, iss_funct3); end
    checks++; if (fetch_ready !== 1'b1) begin failures++; $display("FAIL lsb_ready_back got=%0b exp=1", fetch_ready); end
  endtask

  // Flush with three queued entries and a same-cycle fetch beat
  task automatic test_flush();
    flush = 1'b1; fetch_valid = 1'b1; fetch_instr = 32'h0010_0493; fetch_pc = 32'h90;
    @(negedge clk);
    flush = 1'b0; fetch_valid = 1'b0;
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL flush_issue got=%0b exp=0", issue_valid); end
    checks++; if (fetch_ready !== 1'b1 || iss_pc !== 32'h80) begin failures++; $display("FAIL flush_state got=%0b/%0h exp=1/80", fetch_ready, iss_pc); end
    @(negedge clk);
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got=%0b exp=0", issue_valid); end
    @(negedge clk);
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL flush_beat_dropped got=%0b exp=0", issue_valid); end
  endtask

  // addi x6; addi x7; add x8,x6,x7 with rdy low for three cycles mid-stream
  task automatic test_rdy_freeze();
    rob_tail_id = 4'd9;
    @(negedge clk);
    fetch_valid = 1'b1; fetch_instr = 32'h0010_0313; fetch_pc = 32'h100;
    @(negedge clk);
    fetch_instr = 32'h0020_0393; fetch_pc = 32'h104;
    @(negedge clk);
    checks++; if (issue_valid !== 1'b1 || iss_pc !== 32'h100) begin failures++; $display("FAIL rdy_first got=%0b/%0h exp=1/100", issue_valid, iss_pc); end
    fetch_instr = 32'h0073_0433; fetch_pc = 32'h108; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (issue_valid !== 1'b1 || iss_pc !== 32'h100 || iss_rd !== 5'd6) begin failures++; $display("FAIL rdy_frozen%0d got=%0b/%0h/%0d exp=1/100/6", i, issue_valid, iss_pc, iss_rd); end
    end
    rdy = 1'b1;
    @(negedge clk);
    fetch_valid = 1'b0;
    checks++; if (issue_valid !== 1'b1 || iss_pc !== 32'h104 || iss_rd !== 5'd7) begin failures++; $display("FAIL rdy_resume got=%0b/%0h/%0d exp=1/104/7", issue_valid, iss_pc, iss_rd); end
    checks++; if (reg_id1 !== 5'd6 || reg_id2 !== 5'd7) begin failures++; $display("FAIL rdy_reg_ids got=%0d/%0d exp=6/7", reg_id1, reg_id2); end
    rob_tail_id = 4'd10;
    @(negedge clk);
    checks++; if (issue_valid !== 1'b1 || iss_pc !== 32'h108) begin failures++; $display("FAIL rdy_third got=%0b/%0h exp=1/108", issue_valid, iss_pc); end
    checks++; if (iss_dep1 !== 1'b0 || iss_v1 !== 32'h1234) begin failures++; $display("FAIL rdy_regfile_op got=%0b/%0h exp=0/1234", iss_dep1, iss_v1); end
    checks++; if (iss_dep2 !== 1'b1 || iss_q2 !== 4'd9 || iss_v2 !== 32'h0) begin failures++; $display("FAIL rdy_bypass_op got=%0b/%0d/%0h exp=1/9/0", iss_dep2, iss_q2, iss_v2); end
    checks++; if (iss_rob_id !== 4'd10) begin failures++; $display("FAIL rdy_rob_id got=%0d exp=10", iss_rob_id); end
    @(negedge clk);
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL rdy_drain got=%0b exp=0", issue_valid); end
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_back_to_back();
    test_branch_predict();
    test_lsb_stall();
    test_flush();
    test_rdy_freeze();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
